// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// State encodings are fixed so that display logic can decode the state.
package serial_adder_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between the operand source and the serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned Width = 8
);

  logic             start;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [Width-1:0] s;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder shared by the serial controller.
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder sequenced LSB first over Width cycles,
// with a registered result and a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  state_e           state_q, state_d;
  logic [Width-1:0] a_sh_q, b_sh_q, s_sh_q, s_q;
  logic             carry_q, cout_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic             accept, last_bit, busy, done;
  logic             fa_s, fa_cout;

  serial_adder_ctrl_full_adder u_full_adder (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_cout)
  );

  assign last_bit = (bit_cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        done = 1'b1;
        // Back-to-back: the done cycle may accept the next request.
        if (bus.start) begin
          accept  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      s_sh_q    <= '0;
      s_q       <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else if (accept) begin
      a_sh_q    <= bus.a;
      b_sh_q    <= bus.b;
      carry_q   <= bus.cin;
      bit_cnt_q <= '0;
    end else if (state_q == StRun) begin
      a_sh_q    <= a_sh_q >> 1;
      b_sh_q    <= b_sh_q >> 1;
      s_sh_q    <= {fa_s, s_sh_q[Width-1:1]};
      carry_q   <= fa_cout;
      bit_cnt_q <= bit_cnt_q + CntW'(1);
      if (last_bit) begin
        s_q    <= {fa_s, s_sh_q[Width-1:1]};
        cout_q <= fa_cout;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table plus hand-written
// sequences for start-while-busy, mid-run reset and back-to-back operation.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.Width(W)) bus ();

  serial_adder_ctrl #(.Width(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
  } vec_t;

  vec_t       vecs[10];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_s;
  logic       last_cout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, watch the run, then check timing and result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input string name);
    int cyc;
    int busy_cyc;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.cin   = ~cin;
    cyc       = 0;
    busy_cyc  = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.busy === 1'b1) busy_cyc++;
      check({name, " s hold"}, 32'(bus.s), 32'(last_s));
      cyc++;
      @(negedge clk);
    end
    check({name, " done"}, 32'(bus.done), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'd8);
    check({name, " busy cycles"}, 32'(busy_cyc), 32'd8);
    check({name, " s"}, 32'(bus.s), 32'(es));
    check({name, " cout"}, 32'(bus.cout), 32'(ec));
    last_s    = es;
    last_cout = ec;
    @(negedge clk);
    check({name, " done pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cyc;
    int n_done;

    vecs[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    last_s    = '0;
    last_cout = 1'b0;

    // Reset with start asserted: reset must win.
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset s", 32'(bus.s), 32'd0);
    check("reset cout", 32'(bus.cout), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].cout,
             $sformatf("vec%0d", i));
    end

    // Start while busy is ignored.
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_done    = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        bus.a     = 8'hFF;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("busy start s", 32'(bus.s), 32'h30);
    check("busy start done count", 32'(n_done), 32'd1);
    check("busy start idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of a run.
    bus.a     = 8'h55;
    bus.b     = 8'h55;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst s", 32'(bus.s), 32'd0);
    check("midrst cout", 32'(bus.cout), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    rst_n     = 1'b1;
    last_s    = '0;
    last_cout = 1'b0;
    @(negedge clk);
    check("post rst idle done", 32'(bus.done), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post rst");

    // Back-to-back with start held high.
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    cyc       = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.done !== 1'b1 && cyc < 20);
    check("b2b first latency", 32'(cyc), 32'd9);
    check("b2b first s", 32'(bus.s), 32'h02);
    check("b2b first cout", 32'(bus.cout), 32'd0);
    bus.a = 8'h80;
    bus.b = 8'h80;
    cyc   = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("b2b reaccept busy", 32'(bus.busy), 32'd1);
    end while (bus.done !== 1'b1 && cyc < 20);
    check("b2b spacing", 32'(cyc), 32'd9);
    check("b2b second s", 32'(bus.s), 32'h00);
    check("b2b second cout", 32'(bus.cout), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b end done", 32'(bus.done), 32'd0);
    check("b2b end busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences one shared `FullAdder` instance over two WIDTH-bit operands, one bit per clock, LSB first. It latches operands on a start request, runs the carry through a carry flip-flop, and presents a registered sum and carry-out with a one-cycle done pulse. It is the time-multiplexed front end for the adder datapath in the Basys3 demo: switches provide the operands and the LED and seven-segment logic consume the result.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: request a new addition; sampled only when the controller can accept (see Operation).
- `A`  in  WIDTH: operand A; captured on the accepting edge.
- `B`  in  WIDTH: operand B; captured on the accepting edge.
- `Cin`  in  1: carry-in; captured on the accepting edge.
- `busy`  out  1: high while in RUN.
- `done`  out  1: single-cycle pulse; high in the DONE state.
- `S`  out  WIDTH: registered sum of the last completed operation.
- `Cout`  out  1: registered carry-out of the last completed operation.

## Operation
- State machine with 3 states:
  - IDLE: `busy`=0, `done`=0. If `start`=1, load shift registers `a_sh`←A and `b_sh`←B, set `carry`←Cin, clear `bit_cnt`←0, and go to RUN.
  - RUN: `busy`=1. Each edge does the following:
    - Apply `a_sh[0]`, `b_sh[0]` and `carry` to the FullAdder.
    - Shift `a_sh` and `b_sh` right by one.
    - Shift the FullAdder `S` into the MSB of `s_sh`.
    - Set `carry`←FullAdder `Cout`.
    - Increment `bit_cnt`.
    - On the edge where `bit_cnt`=WIDTH-1: copy the final sum into `S`, the final carry into `Cout`, and go to DONE.
  - DONE: `done`=1, `busy`=0. If `start`=1, reload exactly as in IDLE and go to RUN (back-to-back operation). Otherwise go to IDLE.
- `start` in RUN is ignored. It is not queued.
- `S` and `Cout` change only on the completion edge. They hold the previous result throughout RUN and IDLE.
- `A`, `B` and `Cin` may change freely after the accepting edge without affecting the operation in flight.
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1). There is no overflow flag.
- `bit_cnt` is $clog2(WIDTH) bits wide and wraps to 0 on reload only.
- Reset values: state=IDLE, `busy`=0, `done`=0, `S`=0, `Cout`=0. Internal shift registers, `carry` and `bit_cnt` reset to 0.
- Reset asserted in any state, including mid-RUN, aborts the operation on that edge. No partial result reaches `S` or `Cout`.
- `rst_n`=0 and `start`=1 on the same edge: reset wins.

## Timing
- Accepting edge E0: `start`=1 sampled in IDLE or DONE.
- `busy` is high in cycles E0+1 through E0+WIDTH, exactly WIDTH cycles.
- `S`, `Cout` and `done` become valid after edge E0+WIDTH. `done` is high for exactly one cycle.
- Latency from the accepting edge to `done`: WIDTH cycles.
- Throughput with `start` held high: one result every WIDTH+1 cycles. The DONE cycle accepts the next operation immediately.
- The FullAdder path is combinational between registers. There is no multicycle path.

## Structure
- Shared header `serial_adder_defs.vh` holds the following, so that display logic can decode the state:
  - State encodings: `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2. Encoding 2'd3 recovers to IDLE.
  - The default `WIDTH` constant.
- One sub-module: the existing `FullAdder`, instantiated once. All sequencing stays in `serial_adder_ctrl`.
- Keep the control FSM and the shift/carry datapath in separate always blocks within the one module.

## Test plan
All scenarios use WIDTH=8.

- Basic add: A=0x3C, B=0x42, Cin=0, pulse `start` → `done` 8 cycles after the accepting edge; S=0x7E, Cout=0; `busy` high for exactly 8 cycles.
- Full carry chain: A=0xFF, B=0x01, Cin=0 → S=0x00, Cout=1. Then A=0xA5, B=0x5A, Cin=1 → S=0x00, Cout=1.
- Exhaustive: for all 2×256×256 combinations of A, B and Cin, compare {Cout,S} against A+B+Cin; also check that `S` holds its prior value during every RUN.
- Start while busy: start A=0x10, B=0x20; assert `start` again at RUN cycle 3 with A=0xFF → the second request is ignored; S=0x30 and only one `done` pulse occurs.
- Reset mid-operation: start A=0x55, B=0x55; drive `rst_n`=0 at RUN cycle 4 for one cycle → `S`=0, `Cout`=0, `busy`=0, `done`=0 the next cycle. A fresh add of 0x01+0x01 then gives S=0x02.
- Back-to-back: hold `start`=1 with A=0x01, B=0x01 and then, during the DONE cycle, A=0x80, B=0x80 → results 0x02/Cout=0, then 0x00/Cout=1; `done` pulses 9 cycles apart.
